// File: rtl/clock_pkg.sv
// Shared encodings and defaults for the 12h clock mode controller.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_DISPLAY   = 2'b00,
        MODE_TIME_SET  = 2'b01,
        MODE_ALARM_SET = 2'b10,
        MODE_STOPWATCH = 2'b11
    } mode_e;

    localparam logic [1:0] SETTER_IDLE = 2'b00;

    localparam int unsigned DEF_REPEAT_DELAY = 50;
    localparam int unsigned DEF_REPEAT_RATE  = 10;
    localparam int unsigned DEF_TIMEOUT      = 1000;

    localparam int NUM_BTN  = 4;
    localparam int BTN_MODE = 0;
    localparam int BTN_SET  = 1;
    localparam int BTN_UP   = 2;
    localparam int BTN_DOWN = 3;

    function automatic int cnt_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_DISPLAY:   return MODE_TIME_SET;
            MODE_TIME_SET:  return MODE_ALARM_SET;
            MODE_ALARM_SET: return MODE_STOPWATCH;
            default:        return MODE_DISPLAY;
        endcase
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Rising-edge detector for one button level, with optional hold-to-repeat.
module btn_pulse
    import clock_pkg::*;
#(
    parameter bit          REPEAT_EN = 1'b0,
    parameter int unsigned DELAY     = DEF_REPEAT_DELAY,
    parameter int unsigned RATE      = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic inhibit,
    input  logic clear,
    output logic pulse
);

    localparam int CW = cnt_width(DELAY, RATE);

    logic          prev;
    logic [CW-1:0] cnt;
    logic          press;
    logic          hit;

    // cnt==0 means disarmed: a button held through reset or a mode change never repeats.
    assign press = btn & ~prev;
    assign hit   = REPEAT_EN && btn && (cnt == CW'(DELAY)) && !inhibit;
    assign pulse = press | hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev <= 1'b1;
            cnt  <= '0;
        end else begin
            prev <= btn;
            if (clear || !btn)
                cnt <= '0;
            else if (press)
                cnt <= CW'(1);
            else if (cnt == CW'(DELAY))
                cnt <= CW'(DELAY - RATE + 1);
            else if (cnt != '0)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer: button pulses, setter enables, edit commit and idle-timeout abort.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       set_btn,
    input  logic       up_btn,
    input  logic       down_btn,
    input  logic [1:0] time_state,
    input  logic [1:0] alarm_state,
    input  logic       time_propagate,
    input  logic       alarm_propagate,
    output logic [1:0] mode,
    output logic       time_set_en,
    output logic       alarm_set_en,
    output logic       sw_en,
    output logic       set_p,
    output logic       up_p,
    output logic       down_p,
    output logic       load_time,
    output logic       load_alarm,
    output logic       setter_abort
);

    localparam int IW = cnt_width(cnt_width(REPEAT_DELAY, REPEAT_RATE), TIMEOUT) > cnt_width(REPEAT_DELAY, TIMEOUT)
                        ? cnt_width(REPEAT_DELAY, REPEAT_RATE) : cnt_width(REPEAT_DELAY, TIMEOUT);

    logic [NUM_BTN-1:0] btn;
    logic [NUM_BTN-1:0] btn_inh;
    logic [NUM_BTN-1:0] btn_pls;
    logic               mode_chg;

    mode_e         mode_q, mode_n;
    logic [IW-1:0] idle_q, idle_n;
    logic          set_n, up_n, down_n, load_t_n, load_a_n, abort_n;
    logic          set_cmd, up_cmd, down_cmd, cmd_any, in_setter, setter_idle;

    assign btn     = {down_btn, up_btn, set_btn, mode_btn};
    assign btn_inh = {up_btn, down_btn, 2'b00};

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            btn_pulse #(
                .REPEAT_EN (i == BTN_UP || i == BTN_DOWN),
                .DELAY     (REPEAT_DELAY),
                .RATE      (REPEAT_RATE)
            ) u_btn (
                .clk     (clk),
                .reset   (reset),
                .btn     (btn[i]),
                .inhibit (btn_inh[i]),
                .clear   (mode_chg),
                .pulse   (btn_pls[i])
            );
        end
    endgenerate

    always_comb begin
        mode_n   = mode_q;
        idle_n   = '0;
        set_n    = 1'b0;
        up_n     = 1'b0;
        down_n   = 1'b0;
        load_t_n = 1'b0;
        load_a_n = 1'b0;
        abort_n  = 1'b0;

        // Up wins when both command edges land together.
        up_cmd   = btn_pls[BTN_UP];
        down_cmd = btn_pls[BTN_DOWN] & ~btn_pls[BTN_UP];
        set_cmd  = btn_pls[BTN_SET];
        cmd_any  = up_cmd | down_cmd | set_cmd;

        in_setter   = (mode_q == MODE_TIME_SET) || (mode_q == MODE_ALARM_SET);
        setter_idle = 1'b1;
        if (mode_q == MODE_TIME_SET)
            setter_idle = (time_state == SETTER_IDLE);
        else if (mode_q == MODE_ALARM_SET)
            setter_idle = (alarm_state == SETTER_IDLE);

        // Priority: commit, mode advance, timeout abort, then command forwarding.
        if (mode_q == MODE_TIME_SET && time_propagate) begin
            mode_n   = MODE_DISPLAY;
            load_t_n = 1'b1;
        end else if (mode_q == MODE_ALARM_SET && alarm_propagate) begin
            mode_n   = MODE_DISPLAY;
            load_a_n = 1'b1;
        end else if (btn_pls[BTN_MODE] && setter_idle) begin
            mode_n = next_mode(mode_q);
        end else if (in_setter && !cmd_any && idle_q == IW'(TIMEOUT - 1)) begin
            mode_n  = MODE_DISPLAY;
            abort_n = 1'b1;
        end else if (mode_q != MODE_DISPLAY) begin
            set_n  = set_cmd;
            up_n   = up_cmd;
            down_n = down_cmd;
        end

        if (in_setter && mode_n == mode_q && !cmd_any)
            idle_n = idle_q + 1'b1;
    end

    assign mode_chg = (mode_n != mode_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q       <= MODE_DISPLAY;
            idle_q       <= '0;
            time_set_en  <= 1'b0;
            alarm_set_en <= 1'b0;
            sw_en        <= 1'b0;
            set_p        <= 1'b0;
            up_p         <= 1'b0;
            down_p       <= 1'b0;
            load_time    <= 1'b0;
            load_alarm   <= 1'b0;
            setter_abort <= 1'b0;
        end else begin
            mode_q       <= mode_n;
            idle_q       <= idle_n;
            time_set_en  <= (mode_n == MODE_TIME_SET);
            alarm_set_en <= (mode_n == MODE_ALARM_SET);
            sw_en        <= (mode_n == MODE_STOPWATCH);
            set_p        <= set_n;
            up_p         <= up_n;
            down_p       <= down_n;
            load_time    <= load_t_n;
            load_alarm   <= load_a_n;
            setter_abort <= abort_n;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed scenarios plus random button traffic, checked against a cycle-level reference model.
module tb_clock_mode_ctrl;

    localparam int DLY  = 50;
    localparam int RATE = 10;
    localparam int TMO  = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode_btn = 1'b0, set_btn = 1'b0, up_btn = 1'b0, down_btn = 1'b0;
    logic [1:0] time_state = 2'b00, alarm_state = 2'b00;
    logic       time_propagate = 1'b0, alarm_propagate = 1'b0;
    logic [1:0] mode;
    logic       time_set_en, alarm_set_en, sw_en, set_p, up_p, down_p;
    logic       load_time, load_alarm, setter_abort;

    always #5 clk = ~clk;

    clock_mode_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .mode_btn        (mode_btn),
        .set_btn         (set_btn),
        .up_btn          (up_btn),
        .down_btn        (down_btn),
        .time_state      (time_state),
        .alarm_state     (alarm_state),
        .time_propagate  (time_propagate),
        .alarm_propagate (alarm_propagate),
        .mode            (mode),
        .time_set_en     (time_set_en),
        .alarm_set_en    (alarm_set_en),
        .sw_en           (sw_en),
        .set_p           (set_p),
        .up_p            (up_p),
        .down_p          (down_p),
        .load_time       (load_time),
        .load_alarm      (load_alarm),
        .setter_abort    (setter_abort)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference state: mode number, last button levels, time since up/down press, idle edges.
    int         m_mode = 0;
    bit         m_prev[4] = '{1, 1, 1, 1};
    bit         m_armed[2] = '{0, 0};
    int         m_t[2] = '{0, 0};
    int         m_idle = 0;
    logic [1:0] e_mode;
    bit         e_ten, e_aen, e_sw, e_set, e_up, e_dn, e_lt, e_la, e_ab;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit lvl[4];
        bit edg[4];
        bit rep[2];
        bit up, dn, st, cmd, setter, busy;
        int nm;
        lvl = '{mode_btn, set_btn, up_btn, down_btn};
        {e_set, e_up, e_dn, e_lt, e_la, e_ab} = '0;
        if (!reset) begin
            m_mode  = 0;
            m_idle  = 0;
            m_prev  = '{1, 1, 1, 1};
            m_armed = '{0, 0};
        end else begin
            for (int i = 0; i < 4; i++) edg[i] = lvl[i] && !m_prev[i];
            for (int k = 0; k < 2; k++) begin
                rep[k] = 0;
                if (!lvl[2+k]) m_armed[k] = 0;
                else if (edg[2+k]) begin
                    m_armed[k] = 1;
                    m_t[k] = 0;
                end else if (m_armed[k]) begin
                    m_t[k]++;
                    rep[k] = m_t[k] >= DLY && ((m_t[k] - DLY) % RATE) == 0 && !lvl[3-k];
                end
            end
            up  = edg[2] || rep[0];
            dn  = (edg[3] || rep[1]) && !up;
            st  = edg[1];
            cmd = up || dn || st;
            setter = (m_mode == 1) || (m_mode == 2);
            busy   = (m_mode == 1 && time_state != 0) || (m_mode == 2 && alarm_state != 0);
            nm = m_mode;
            if (m_mode == 1 && time_propagate) begin
                nm = 0; e_lt = 1;
            end else if (m_mode == 2 && alarm_propagate) begin
                nm = 0; e_la = 1;
            end else if (edg[0] && !busy) begin
                nm = (m_mode + 1) % 4;
            end else if (setter && !cmd && m_idle + 1 >= TMO) begin
                nm = 0; e_ab = 1;
            end else if (m_mode != 0) begin
                e_set = st; e_up = up; e_dn = dn;
            end
            if (nm != m_mode || !setter || cmd) m_idle = 0;
            else m_idle++;
            if (nm != m_mode) m_armed = '{0, 0};
            m_mode = nm;
            for (int i = 0; i < 4; i++) m_prev[i] = lvl[i];
        end
        e_mode = 2'(m_mode);
        e_ten  = (m_mode == 1);
        e_aen  = (m_mode == 2);
        e_sw   = (m_mode == 3);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("mode", mode, e_mode);
        chk("time_set_en", time_set_en, e_ten);
        chk("alarm_set_en", alarm_set_en, e_aen);
        chk("sw_en", sw_en, e_sw);
        chk("set_p", set_p, e_set);
        chk("up_p", up_p, e_up);
        chk("down_p", down_p, e_dn);
        chk("load_time", load_time, e_lt);
        chk("load_alarm", load_alarm, e_la);
        chk("setter_abort", setter_abort, e_ab);
        chk("onehot_en", 32'(($countones({time_set_en, alarm_set_en, sw_en}) <= 1)), 1);
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        step();
    endtask

    initial begin
        int q[$];
        int exp_off[4] = '{0, 50, 60, 70};
        int n_up, n_idle;
        bit la_seen;

        // Reset with set held: no set pulse on release.
        reset = 1'b0;
        set_btn = 1'b1;
        step();
        step();
        chk("rst_mode", mode, 2'b00);
        chk("rst_abort", setter_abort, 0);
        reset = 1'b1;
        repeat (3) begin
            step();
            chk("rst_hold_set_p", set_p, 0);
        end
        set_btn = 1'b0;
        repeat (3) step();

        // DISPLAY -> TIME_SET, then a set pulse.
        mode_btn = 1'b1;
        step();
        chk("enter_ts_mode", mode, 2'b01);
        chk("enter_ts_en", time_set_en, 1);
        mode_btn = 1'b0;
        set_btn = 1'b1;
        step();
        chk("set_pulse", set_p, 1);
        step();
        chk("set_pulse_once", set_p, 0);
        set_btn = 1'b0;
        step();

        // Up held 80 cycles: pulses at press and 50, 60, 70 edges later.
        up_btn = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (up_p) q.push_back(i);
        end
        up_btn = 1'b0;
        chk("rep_count", q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rep_off%0d", i), (i < q.size()) ? q[i] : -1, exp_off[i]);
        n_up = 0;
        repeat (20) begin
            step();
            n_up += int'(up_p);
        end
        chk("no_up_after_release", n_up, 0);

        // Busy setter blocks mode change; propagate commits.
        time_state = 2'b10;
        mode_btn = 1'b1;
        step();
        chk("busy_block", mode, 2'b01);
        mode_btn = 1'b0;
        step();
        time_propagate = 1'b1;
        step();
        chk("commit_load", load_time, 1);
        chk("commit_mode", mode, 2'b00);
        time_propagate = 1'b0;
        time_state = 2'b00;
        step();
        chk("commit_once", load_time, 0);

        // ALARM_SET idle: abort after TMO idle edges, no load.
        press_mode();
        press_mode();
        chk("in_alarm", mode, 2'b10);
        n_idle = 1;
        la_seen = 0;
        for (int i = 0; i < TMO + 100; i++) begin
            step();
            n_idle++;
            la_seen |= load_alarm;
            if (setter_abort) break;
        end
        chk("abort_at", n_idle, TMO);
        chk("abort_mode", mode, 2'b00);
        chk("abort_no_load", la_seen, 0);
        step();
        chk("abort_once", setter_abort, 0);

        // Propagate on the timeout edge: commit wins.
        press_mode();
        repeat (TMO - 2) step();
        time_propagate = 1'b1;
        step();
        chk("tmo_commit_load", load_time, 1);
        chk("tmo_commit_noabort", setter_abort, 0);
        time_propagate = 1'b0;
        step();

        // Simultaneous up/down edges: up only.
        press_mode();
        up_btn = 1'b1;
        down_btn = 1'b1;
        step();
        chk("updn_up", up_p, 1);
        chk("updn_down", down_p, 0);
        up_btn = 1'b0;
        down_btn = 1'b0;
        step();

        // Reset mid-edit: back to DISPLAY with no abort or load.
        time_state = 2'b01;
        reset = 1'b0;
        step();
        chk("rst_edit_mode", mode, 2'b00);
        chk("rst_edit_abort", setter_abort, 0);
        chk("rst_edit_load", load_time, 0);
        reset = 1'b1;
        time_state = 2'b00;
        step();

        // Random traffic.
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(47) == 0) up_btn = ~up_btn;
            if ($urandom_range(47) == 0) down_btn = ~down_btn;
            if ($urandom_range(4) == 0) set_btn = ~set_btn;
            if ($urandom_range(39) == 0) mode_btn = ~mode_btn;
            time_state  = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
            alarm_state = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
            time_propagate  = ($urandom_range(60) == 0);
            alarm_propagate = ($urandom_range(60) == 0);
            reset = ($urandom_range(399) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
